// File: rtl/spw_babasu_pio_pkg.sv
// Shared register offsets and edge-type codes for the PIO capture block.
package spw_babasu_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/spw_babasu_pio_sync.sv
// Multi-stage synchroniser bringing asynchronous PIO inputs into the clk domain.
module spw_babasu_pio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/spw_babasu_pio_capture.sv
// PIO input port with edge capture, per-bit interrupt mask and registered readback.
module spw_babasu_pio_capture
    import spw_babasu_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int IRQ_ENABLE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       settle_q, settle_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clear_mask;
    logic             wr_en;
    logic             unused_wdata;

    spw_babasu_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .in_i    (in_port),
        .sync_o  (sync_w)
    );

    // Bits of writedata above WIDTH are deliberately dropped.
    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;

    always_comb begin
        edge_det   = '0;
        clear_mask = '0;
        settle_d   = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 3'd1;
        // Hold off detection until the sync chain and prev hold post-reset input.
        if (settle_q == SETTLE_MAX) begin
            case (EDGE_TYPE)
                EDGE_RISE: edge_det = sync_w & ~prev_q;
                EDGE_FALL: edge_det = ~sync_w & prev_q;
                default:   edge_det = sync_w ^ prev_q;
            endcase
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            clear_mask = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clear_mask) | edge_det;

        irqmask_d = irqmask_q;
        if (IRQ_ENABLE == 0) begin
            irqmask_d = '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        irq_d = (IRQ_ENABLE != 0) && (|(edgecap_q & irqmask_q));

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d = 32'(sync_w);
            ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
            ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            settle_q   <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= sync_w;
            settle_q   <= settle_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_spw_babasu_pio_capture.sv
// Directed bench: rising-edge instance (dut_a) and any-edge instance (dut_b) on a shared bus.
module tb_spw_babasu_pio_capture;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs_a, cs_b;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_a, in_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int checks   = 0;
    int failures = 0;

    spw_babasu_pio_capture #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2), .IRQ_ENABLE(1)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs_a),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_a),
        .readdata   (rd_a),
        .irq        (irq_a)
    );

    spw_babasu_pio_capture #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2), .IRQ_ENABLE(1)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs_b),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_b),
        .readdata   (rd_b),
        .irq        (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit to_b, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        if (to_b) cs_b = 1'b1; else cs_a = 1'b1;
        tick(1);
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
        address   = 2'd3;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
        in_a      = 8'hFF;
        in_b      = 8'h00;
        tick(3);
        chk("reset_readdata", rd_a, 32'h0);
        chk("reset_irq", 32'(irq_a), 32'h0);

        // Inputs held high through reset must not produce captures.
        reset_n = 1'b1;
        tick(10);
        chk("data_after_reset", rd_a, 32'h0000_00FF);
        address = 2'd3;
        tick(1);
        chk("no_spurious_capture", rd_a, 32'h0);
        chk("no_spurious_irq", 32'(irq_a), 32'h0);

        wr(0, 2'd2, 32'h1);
        address = 2'd2;
        tick(1);
        chk("mask_readback", rd_a, 32'h1);

        address = 2'd3;
        in_a = 8'hFE;
        tick(5);
        chk("falling_ignored", rd_a, 32'h0);

        in_a = 8'hFF;
        tick(3);
        chk("capture_not_early", rd_a, 32'h0);
        chk("irq_not_early", 32'(irq_a), 32'h0);
        tick(1);
        chk("capture_bit0", rd_a, 32'h1);
        chk("irq_bit0", 32'(irq_a), 32'h1);

        wr(0, 2'd3, 32'h1);
        chk("irq_holds_one_cycle", 32'(irq_a), 32'h1);
        tick(1);
        chk("w1c_bit0", rd_a, 32'h0);
        chk("irq_dropped", 32'(irq_a), 32'h0);

        wr(0, 2'd0, 32'h0);
        wr(0, 2'd1, 32'hFFFF_FFFF);
        address = 2'd1;
        tick(1);
        chk("rsvd_reads_zero", rd_a, 32'h0);
        address = 2'd0;
        tick(1);
        chk("data_write_ignored", rd_a, 32'h0000_00FF);
        wr(0, 2'd2, 32'hFFFF_FF01);
        address = 2'd2;
        tick(1);
        chk("mask_upper_ignored", rd_a, 32'h1);

        address = 2'd3;
        in_a = 8'hF7;
        tick(4);
        in_a = 8'hFF;
        tick(4);
        chk("capture_bit3", rd_a, 32'h8);
        chk("irq_masked_bit3", 32'(irq_a), 32'h0);
        in_a = 8'hF7;
        tick(4);
        chk("bit3_held", rd_a, 32'h8);
        // Time the W1C so it lands on the same edge that captures bit 3 again.
        in_a = 8'hFF;
        tick(2);
        wr(0, 2'd3, 32'h8);
        tick(1);
        chk("set_wins_over_clear", rd_a, 32'h8);
        wr(0, 2'd3, 32'h8);
        tick(1);
        chk("w1c_bit3", rd_a, 32'h0);

        in_b = 8'h20;
        tick(4);
        chk("any_capture_rise", rd_b, 32'h20);
        chk("any_irq_masked_rise", 32'(irq_b), 32'h0);
        wr(1, 2'd3, 32'h20);
        tick(1);
        chk("any_w1c", rd_b, 32'h0);
        in_b = 8'h00;
        tick(4);
        chk("any_capture_fall", rd_b, 32'h20);
        chk("any_irq_masked_fall", 32'(irq_b), 32'h0);

        wr(0, 2'd2, 32'hFF);
        in_a = 8'h5A;
        tick(4);
        in_a = 8'hFF;
        tick(4);
        chk("capture_a5", rd_a, 32'hA5);
        chk("irq_a5", 32'(irq_a), 32'h1);

        reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", rd_a, 32'h0);
        chk("async_reset_irq", 32'(irq_a), 32'h0);
        chk("async_reset_edgecap", 32'(dut_a.edgecap_q), 32'h0);
        chk("async_reset_irqmask", 32'(dut_a.irqmask_q), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        address = 2'd2;
        tick(1);
        chk("mask_after_rereset", rd_a, 32'h0);
        address = 2'd3;
        tick(1);
        chk("edgecap_after_rereset", rd_a, 32'h0);
        chk("irq_after_rereset", 32'(irq_a), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spw_babasu_pio_capture.md
SPW_BABASU_PIO_CAPTURE -- requirements
Module: spw_babasu_pio_capture

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, input port width, legal 1..32.
REQ-002 The block SHALL take parameter EDGE_TYPE, default 0, capture edge: 0 rising, 1 falling, 2 any.
REQ-003 The block SHALL take parameter SYNC_STAGES, default 2, input synchroniser depth, legal 2..3.
REQ-004 The block SHALL take parameter IRQ_ENABLE, default 1; when 0, irq is tied 0 and the mask register reads 0.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port address  in  2  register word select.
REQ-007 The block SHALL have port chipselect  in  1  slave selected this cycle.
REQ-008 The block SHALL have port write_n  in  1  active-low write strobe, qualified by chipselect.
REQ-009 The block SHALL have port writedata  in  32  write data.
REQ-010 The block SHALL have port in_port  in  WIDTH  asynchronous external inputs.
REQ-011 The block SHALL have port readdata  out  32  registered read data.
REQ-012 The block SHALL have port irq  out  1  registered level interrupt.

Function
REQ-013 in_port SHALL pass through SYNC_STAGES flops per bit (sync); a further flop (prev) SHALL hold the previous synchronised value.
REQ-014 Edge detect per bit SHALL be: rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev.
REQ-015 A settle counter SHALL count SYNC_STAGES+1 cycles after reset release; edge detection SHALL be suppressed until it saturates, so no spurious capture from inputs held static through reset.
REQ-016 Register map: 0 data (RO, synchronised value); 1 reserved (reads 0, writes ignored); 2 irqmask (RW, WIDTH bits); 3 edgecapture (read; write-1-to-clear per bit).
REQ-017 readdata SHALL update every cycle from the address mux, one cycle latency, independent of chipselect; bits 31:WIDTH SHALL read 0.
REQ-018 A write occurs when chipselect=1 and write_n=0; the register takes effect the following cycle.
REQ-019 edgecapture bit SHALL set on a detected edge and hold until cleared by a write of 1 to that bit at address 3.
REQ-020 Simultaneous edge detect and write-1-clear on the same bit SHALL leave the bit set (set wins).
REQ-021 irq SHALL be registered: irq(n+1) = |(edgecapture(n) & irqmask(n)).
REQ-022 Writes to address 0 or 1 SHALL have no effect; writedata bits above WIDTH SHALL be ignored.

Reset
REQ-023 On reset_n low, asynchronously: readdata=0, irq=0, irqmask=0, edgecapture=0, sync and prev flops=0, settle counter=0.
REQ-024 Reset asserted mid-operation SHALL discard pending captures; after release REQ-015 applies again.

Structure
REQ-025 Register offsets (DATA=0, RSVD=1, IRQMASK=2, EDGECAP=3) and EDGE_TYPE codes (RISE, FALL, ANY) SHALL live in shared package spw_babasu_pio_pkg.
REQ-026 The synchroniser SHALL be sub-module spw_babasu_pio_sync, parametrised by WIDTH and SYNC_STAGES, same clock and reset.

Verification
REQ-027 Reset with in_port=8'hFF held, release -> no edgecapture bits set after 10 cycles; address 0 reads 32'h000000FF.
REQ-028 EDGE_TYPE=0, mask=8'h01, pulse in_port[0] 0->1 -> edgecapture=8'h01 within SYNC_STAGES+2 cycles, irq=1 one cycle later.
REQ-029 Write 32'h00000001 to address 3 -> edgecapture bit 0 clears next cycle, irq drops one cycle after.
REQ-030 Edge on bit 3 in same cycle as W1C of bit 3 -> bit 3 remains 1.
REQ-031 EDGE_TYPE=2, toggle in_port[5] high then low, clear between -> two captures; mask=0 -> irq stays 0.
REQ-032 Assert reset_n with edgecapture=8'hA5, irqmask=8'hFF -> readdata, irq, edgecapture, irqmask all 0 immediately.
